// File: rtl/disp_pkg.sv
// Shared constants, state type and bit-offset helper for the display source selector
// and its companion blocks.
package disp_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HOUR = 2;

  localparam int SRC_AUTO      = 0;
  localparam int SRC_MANUAL    = 1;
  localparam int SRC_ALARM     = 2;
  localparam int SRC_STOPWATCH = 3;

  typedef enum logic {
    ST_NORMAL,
    ST_PEEK
  } peek_state_e;

  // Flat offset of (source, digit) in a bank-major bus; pass width=1 for per-digit flag buses.
  function automatic int digit_offset(input int src, input int dig, input int ndig, input int width);
    return (src * ndig + dig) * width;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Free-running blink phase generator with restart; phase_next is exposed so callers
// can register display data that agrees with the phase register on the same edge.
module blink_gen #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic phase,
  output logic phase_next
);

  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (!enable || restart) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt_next   = '0;
      phase_next = ~phase;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/disp_src_mux_seq.sv
// Registered display-source selector: picks a digit bank, applies per-digit blanking,
// blinks the edited field and supports a timed peek at another source.
module disp_src_mux_seq #(
  parameter int NSRC       = 4,
  parameter int NDIG       = 6,
  parameter int DW         = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int PEEK_TICKS = 5,
  parameter logic [DW-1:0] BLANK_CODE = DW'(disp_pkg::BLANK_CODE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC*NDIG*DW-1:0]   src_digits,
  input  logic [NSRC*NDIG-1:0]      src_blank,
  input  logic [$clog2(NSRC)-1:0]   mode_sel,
  input  logic                      edit_en,
  input  logic [1:0]                edit_field,
  input  logic                      tick_1hz,
  input  logic                      peek_req,
  input  logic [$clog2(NSRC)-1:0]   peek_src,
  output logic [NDIG*DW-1:0]        disp_digits,
  output logic [$clog2(NSRC)-1:0]   disp_src,
  output logic                      blink_phase,
  output logic                      peek_active
);

  import disp_pkg::*;

  localparam int SW   = $clog2(NSRC);
  localparam int PW   = $clog2(PEEK_TICKS + 1);
  localparam int NFLD = NDIG / 2;

  peek_state_e     state, state_next;
  logic [SW-1:0]   peek_sel, peek_sel_next;
  logic [PW-1:0]   peek_cnt, peek_cnt_next;
  logic [SW-1:0]   mode_sel_q;
  logic            edit_en_q;
  logic [1:0]      edit_field_q;
  logic            blink_restart;
  logic            phase_next;
  logic [SW-1:0]   active_idx;
  logic [NDIG*DW-1:0] digits_next;

  assign blink_restart = (edit_en & ~edit_en_q) | (edit_field != edit_field_q);

  blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk        (clk),
    .rst        (rst),
    .enable     (edit_en),
    .restart    (blink_restart),
    .phase      (blink_phase),
    .phase_next (phase_next)
  );

  // A new peek request outranks both an abort and a tick arriving in the same cycle.
  always_comb begin
    state_next    = state;
    peek_sel_next = peek_sel;
    peek_cnt_next = peek_cnt;
    case (state)
      ST_NORMAL: begin
        if (peek_req) begin
          state_next    = ST_PEEK;
          peek_sel_next = peek_src;
          peek_cnt_next = PW'(PEEK_TICKS);
        end
      end
      ST_PEEK: begin
        if (peek_req) begin
          peek_sel_next = peek_src;
          peek_cnt_next = PW'(PEEK_TICKS);
        end else if (mode_sel != mode_sel_q) begin
          state_next    = ST_NORMAL;
          peek_cnt_next = '0;
        end else if (tick_1hz) begin
          if (peek_cnt == PW'(1)) begin
            state_next    = ST_NORMAL;
            peek_cnt_next = '0;
          end else begin
            peek_cnt_next = peek_cnt - PW'(1);
          end
        end
      end
    endcase
  end

  assign active_idx = (state_next == ST_PEEK) ? peek_sel_next : mode_sel;

  // Indices with no matching bank fall through to the all-blank default.
  always_comb begin
    digits_next = {NDIG{BLANK_CODE}};
    for (int s = 0; s < NSRC; s++) begin
      if (active_idx == SW'(s)) begin
        for (int d = 0; d < NDIG; d++) begin
          if (!src_blank[digit_offset(s, d, NDIG, 1)]) begin
            digits_next[d*DW +: DW] = src_digits[digit_offset(s, d, NDIG, DW) +: DW];
          end
        end
      end
    end
    if (edit_en && !phase_next && (state_next == ST_NORMAL) && (int'(edit_field) < NFLD)) begin
      for (int d = 0; d < NDIG; d++) begin
        if ((d / 2) == int'(edit_field)) begin
          digits_next[d*DW +: DW] = BLANK_CODE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_NORMAL;
      peek_sel     <= '0;
      peek_cnt     <= '0;
      mode_sel_q   <= '0;
      edit_en_q    <= 1'b0;
      edit_field_q <= '0;
      disp_digits  <= {NDIG{BLANK_CODE}};
      disp_src     <= '0;
      peek_active  <= 1'b0;
    end else begin
      state        <= state_next;
      peek_sel     <= peek_sel_next;
      peek_cnt     <= peek_cnt_next;
      mode_sel_q   <= mode_sel;
      edit_en_q    <= edit_en;
      edit_field_q <= edit_field;
      disp_digits  <= digits_next;
      disp_src     <= active_idx;
      peek_active  <= (state_next == ST_PEEK);
    end
  end

endmodule

// File: tb/tb_disp_src_mux_seq.sv
// Scoreboard bench for disp_src_mux_seq: directed vectors push expected outputs,
// a monitor pops and compares after each clock edge or reset assertion.
module tb_disp_src_mux_seq;

  import disp_pkg::*;

  localparam int NSRC       = 3;
  localparam int NDIG       = 6;
  localparam int DW         = 4;
  localparam int BLINK_DIV  = 4;
  localparam int PEEK_TICKS = 3;

  localparam logic [23:0] B0 = 24'h102030;
  localparam logic [23:0] B1 = 24'h090807;
  localparam logic [23:0] B2 = 24'h123456;
  localparam logic [23:0] BL = 24'hFFFFFF;

  typedef struct {
    string       name;
    logic [23:0] digits;
    logic [1:0]  src;
    logic        phase;
    logic        peek;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] src_digits;
  logic [17:0] src_blank = '0;
  logic [1:0]  mode_sel = '0;
  logic        edit_en = 1'b0;
  logic [1:0]  edit_field = '0;
  logic        tick_1hz = 1'b0;
  logic        peek_req = 1'b0;
  logic [1:0]  peek_src = '0;
  logic [23:0] disp_digits;
  logic [1:0]  disp_src;
  logic        blink_phase;
  logic        peek_active;

  logic        s_rst = 1'b1;
  logic [17:0] s_blank = '0;
  logic [1:0]  s_mode = '0;
  logic        s_edit_en = 1'b0;
  logic [1:0]  s_field = '0;
  logic        s_tick = 1'b0;
  logic        s_peek = 1'b0;
  logic [1:0]  s_psrc = '0;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  disp_src_mux_seq #(
    .NSRC       (NSRC),
    .NDIG       (NDIG),
    .DW         (DW),
    .BLINK_DIV  (BLINK_DIV),
    .PEEK_TICKS (PEEK_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_digits  (src_digits),
    .src_blank   (src_blank),
    .mode_sel    (mode_sel),
    .edit_en     (edit_en),
    .edit_field  (edit_field),
    .tick_1hz    (tick_1hz),
    .peek_req    (peek_req),
    .peek_src    (peek_src),
    .disp_digits (disp_digits),
    .disp_src    (disp_src),
    .blink_phase (blink_phase),
    .peek_active (peek_active)
  );

  task automatic pushExpect(input string name, input logic [23:0] ed, input logic [1:0] es,
                            input logic ep, input logic ek);
    exp_t e;
    e.name   = name;
    e.digits = ed;
    e.src    = es;
    e.phase  = ep;
    e.peek   = ek;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic [23:0] ed, input logic [1:0] es,
                               input logic ep, input logic ek);
    @(negedge clk);
    rst        = s_rst;
    src_blank  = s_blank;
    mode_sel   = s_mode;
    edit_en    = s_edit_en;
    edit_field = s_field;
    tick_1hz   = s_tick;
    peek_req   = s_peek;
    peek_src   = s_psrc;
    pushExpect(name, ed, es, ep, ek);
    s_tick = 1'b0;
    s_peek = 1'b0;
  endtask

  task automatic applyReset(input string name);
    @(negedge clk);
    pushExpect(name, BL, 2'd0, 1'b1, 1'b0);
    #2;
    rst   = 1'b1;
    s_rst = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (disp_digits !== e.digits || disp_src !== e.src ||
        blink_phase !== e.phase || peek_active !== e.peek) begin
      miscompares++;
      $display("[TB] FAIL %s: got digits=%h src=%0d phase=%b peek=%b, expected digits=%h src=%0d phase=%b peek=%b",
               e.name, disp_digits, disp_src, blink_phase, peek_active,
               e.digits, e.src, e.phase, e.peek);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    src_digits = {B2, B1, B0};

    applyStimulus("reset_hold", BL, 2'd0, 1'b1, 1'b0);
    s_rst = 1'b0;
    applyStimulus("reset_release", B0, 2'd0, 1'b1, 1'b0);

    s_mode = 2'(SRC_ALARM);
    applyStimulus("mode_sel_2", B2, 2'd2, 1'b1, 1'b0);
    s_blank = 18'h03000;
    applyStimulus("bank2_sec_blank", 24'h1234FF, 2'd2, 1'b1, 1'b0);
    s_blank = '0;
    s_mode  = 2'(SRC_MANUAL);
    applyStimulus("mode_sel_1", B1, 2'd1, 1'b1, 1'b0);

    s_mode    = 2'd2;
    s_edit_en = 1'b1;
    s_field   = 2'(FIELD_MIN);
    for (int i = 0; i < 13; i++) begin
      if (((i / 4) % 2) == 0) applyStimulus("blink_min_visible", B2, 2'd2, 1'b1, 1'b0);
      else                    applyStimulus("blink_min_blanked", 24'h12FF56, 2'd2, 1'b0, 1'b0);
    end
    s_field = 2'(FIELD_HOUR);
    applyStimulus("field_change_restart", B2, 2'd2, 1'b1, 1'b0);
    s_edit_en = 1'b0;
    applyStimulus("edit_off", B2, 2'd2, 1'b1, 1'b0);

    s_mode = 2'd0;
    applyStimulus("mode_sel_0", B0, 2'd0, 1'b1, 1'b0);
    s_peek = 1'b1; s_psrc = 2'd2;
    applyStimulus("peek_start", B2, 2'd2, 1'b1, 1'b1);
    applyStimulus("peek_idle", B2, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s_tick = 1'b1;
      applyStimulus("peek_tick", B2, 2'd2, 1'b1, 1'b1);
    end
    s_tick = 1'b1;
    applyStimulus("peek_tick3_end", B0, 2'd0, 1'b1, 1'b0);

    s_peek = 1'b1; s_psrc = 2'd1;
    applyStimulus("peek2_start", B1, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s_tick = 1'b1;
      applyStimulus("peek2_tick", B1, 2'd1, 1'b1, 1'b1);
    end
    s_peek = 1'b1; s_psrc = 2'd2;
    applyStimulus("peek2_restart", B2, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s_tick = 1'b1;
      applyStimulus("peek2_extended_tick", B2, 2'd2, 1'b1, 1'b1);
    end
    s_tick = 1'b1;
    applyStimulus("peek2_end", B0, 2'd0, 1'b1, 1'b0);

    s_peek = 1'b1; s_psrc = 2'd2;
    applyStimulus("peek3_start", B2, 2'd2, 1'b1, 1'b1);
    s_mode = 2'd1;
    applyStimulus("mode_change_abort", B1, 2'd1, 1'b1, 1'b0);

    s_peek = 1'b1; s_psrc = 2'd2;
    applyStimulus("peek4_start", B2, 2'd2, 1'b1, 1'b1);
    s_tick = 1'b1;
    applyStimulus("peek4_tick", B2, 2'd2, 1'b1, 1'b1);
    s_tick = 1'b1; s_peek = 1'b1; s_psrc = 2'd2;
    applyStimulus("peek_tick_coincide", B2, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s_tick = 1'b1;
      applyStimulus("peek4_reloaded_tick", B2, 2'd2, 1'b1, 1'b1);
    end
    s_tick = 1'b1;
    applyStimulus("peek4_end", B1, 2'd1, 1'b1, 1'b0);

    s_peek = 1'b1; s_psrc = 2'd0;
    applyStimulus("peek5_start", B0, 2'd0, 1'b1, 1'b1);
    s_mode = 2'd2; s_peek = 1'b1; s_psrc = 2'd1;
    applyStimulus("peek_beats_abort", B1, 2'd1, 1'b1, 1'b1);
    applyStimulus("peek5_hold", B1, 2'd1, 1'b1, 1'b1);
    s_mode = 2'd0;
    applyStimulus("peek5_abort", B0, 2'd0, 1'b1, 1'b0);

    s_mode = 2'd3;
    applyStimulus("mode_out_of_range", BL, 2'd3, 1'b1, 1'b0);

    s_mode = 2'd0; s_edit_en = 1'b1; s_field = 2'(FIELD_SEC);
    s_peek = 1'b1; s_psrc = 2'd2;
    applyStimulus("peek6_start", B2, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("peek6_phase_high", B2, 2'd2, 1'b1, 1'b1);
    applyStimulus("peek6_no_blink", B2, 2'd2, 1'b0, 1'b1);
    applyReset("reset_mid_peek");
    applyStimulus("reset_hold2", BL, 2'd0, 1'b1, 1'b0);
    s_rst = 1'b0; s_edit_en = 1'b0;
    applyStimulus("reset_release2", B0, 2'd0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/disp_src_mux_seq.md
Name: disp_src_mux_seq

Overview:
- Registered, parametrised display-source selector for the clock front end.
- Picks one of NSRC digit banks (auto time, manual set, alarm set, stopwatch, ...) for the seven-segment scan driver.
- Adds per-source digit blanking, edit-field blinking and a timed "peek" that temporarily shows another source before reverting.
- Sits between the time/alarm/stopwatch counters and the segment scan/decoder block.

Parameters:
NSRC, 4, number of digit-bank sources (>=2)
NDIG, 6, digits per bank; must be even; digit 2f = field f low digit, 2f+1 = high digit (0 sec, 1 min, 2 hour)
DW, 4, bits per digit (BCD)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)
PEEK_TICKS, 5, tick_1hz pulses a peek lasts (>=1)
BLANK_CODE, 4'hF, digit code the decoder renders as all segments off

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
src_digits  in  NSRC*NDIG*DW  bank s, digit d at bits [(s*NDIG+d)*DW +: DW]
src_blank  in  NSRC*NDIG  bit s*NDIG+d = 1 forces digit d of bank s to BLANK_CODE
mode_sel  in  $clog2(NSRC)  normal source index
edit_en  in  1  1 = a field is being hand-edited, blink it
edit_field  in  2  field index being edited (0..NDIG/2-1; larger = no blinking)
tick_1hz  in  1  one-cycle pulse per second
peek_req  in  1  one-cycle pulse: start/restart peek
peek_src  in  $clog2(NSRC)  source shown during peek, sampled with peek_req
disp_digits  out  NDIG*DW  registered display digits
disp_src  out  $clog2(NSRC)  source index currently driving disp_digits
blink_phase  out  1  1 = edited field visible, 0 = blanked
peek_active  out  1  1 while in PEEK state

Behaviour:
- Reset (async, immediate): disp_digits all BLANK_CODE, disp_src 0, blink_phase 1, peek_active 0, FSM NORMAL, peek counter 0, blink counter 0.
- All outputs are registered. Input change on cycle n is visible on outputs at n+1.
- Active index: NORMAL uses mode_sel; PEEK uses the latched peek source.
- An index >= NSRC blanks every digit; disp_src still reports that index.
- Per digit d, from the active source a: BLANK_CODE if src_blank[a*NDIG+d]. Otherwise BLANK_CODE if blink-blanked (below). Otherwise src_digits digit.
- FSM states:
  - NORMAL: peek_req -> PEEK; latch peek_src; counter = PEEK_TICKS.
  - PEEK, peek_req: relatch peek_src, reload PEEK_TICKS. This has priority over a tick in the same cycle.
  - PEEK, tick_1hz: counter decrements. On the tick where counter==1, go to NORMAL. Peek lasts exactly PEEK_TICKS ticks.
  - PEEK, mode_sel differs from its previous-cycle value: abort to NORMAL that cycle. peek_req in the same cycle wins and stays in PEEK.
- peek_active = (state == PEEK), registered.
- Blink counter:
  - Counts 0..BLINK_DIV-1 while edit_en=1; at wrap it toggles blink_phase.
  - Forced to count 0 with blink_phase=1 when edit_en=0, on an edit_en rising edge, or when edit_field changes. The edited digit is therefore visible immediately after any edit action.
- Blink-blanked condition: edit_en=1, blink_phase=0, state NORMAL, edit_field < NDIG/2, digit d in {2*edit_field, 2*edit_field+1}.
- No blinking in PEEK. The counter keeps running during PEEK.
- Width rules: counters sized $clog2(BLINK_DIV) and $clog2(PEEK_TICKS+1). No truncation warnings.

Decomposition:
- Shared package disp_pkg holds:
  - BLANK_CODE
  - field index constants FIELD_SEC=0, FIELD_MIN=1, FIELD_HOUR=2
  - source index constants SRC_AUTO=0, SRC_MANUAL=1, SRC_ALARM=2, SRC_STOPWATCH=3
  - a function returning the flat bit offset of (source, digit)
- One sub-module is natural: blink_gen (BLINK_DIV parameter; inputs enable and restart; output phase). It is reusable by the LED alarm indicator.

Test Plan:
1. Reset asserted mid-PEEK with edit blinking -> same cycle: disp_digits all 4'hF, peek_active 0, blink_phase 1. After release with mode_sel=0: source 0 digits appear one cycle later.
2. NSRC=4, mode_sel 0->2 with bank2=12:34:56 -> next cycle disp_digits = {1,2,3,4,5,6} high-to-low and disp_src=2. Set src_blank bits 0,1 of bank 2 -> secL/secH = 4'hF.
3. BLINK_DIV=4, edit_en=1, edit_field=1 -> minL/minH visible 4 cycles, blanked 4, visible 4. Changing edit_field to 2 mid-blank -> hours visible next cycle and minutes restored.
4. PEEK_TICKS=3, peek_req with peek_src=2 -> bank 2 shown for exactly 3 tick_1hz pulses, then mode_sel source. A second peek_req after tick 2 extends the peek to 3 more ticks.
5. During PEEK, toggle mode_sel -> next cycle peek_active=0 and the new mode_sel source is shown. peek_req coincident with a tick in the same cycle -> counter reloads, no decrement.
6. mode_sel=3 with NSRC=3 -> all digits 4'hF, disp_src=3.
